// File: rtl/imm_pkg.sv
// imm_pkg: shared immediate-format definitions for the decode path.
//   imm_src_t  : immediate format selector (I/S/B/U/J/Z; 110/111 reserved)
//   imm_ext_t  : extended immediate at the widest supported XLEN plus illegal flag
//   imm_extend : combinational extractor/sign-extender; callers truncate to XLEN
package imm_pkg;

  localparam int XLEN_MAX = 64;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_Z = 3'd5
  } imm_src_t;

  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    logic                illegal;
  } imm_ext_t;

  // Result is always built at 64 bits. The low 32 bits of a 64-bit sign
  // extension equal the 32-bit sign extension, so RV32 users just truncate.
  function automatic imm_ext_t imm_extend(input logic [31:0] instr,
                                          input logic [2:0]  src);
    imm_ext_t            r;
    logic [XLEN_MAX-1:0] s;
    s         = {XLEN_MAX{instr[31]}};
    r.imm     = '0;
    r.illegal = 1'b0;
    case (src)
      IMM_I:   r.imm = {s[63:12], instr[31:20]};
      IMM_S:   r.imm = {s[63:12], instr[31:25], instr[11:7]};
      IMM_B:   r.imm = {s[63:12], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   r.imm = {s[63:32], instr[31:12], 12'b0};
      IMM_J:   r.imm = {s[63:20], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z:   r.imm = {59'b0, instr[19:15]};
      // Reserved formats still flow down the pipe, flagged rather than dropped.
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// imm_decode_stage_if: upstream and downstream handshakes of the immediate
// decode stage.
//   in_*  : instruction, format, pc with valid/ready (stage is the sink)
//   out_* : imm, target, illegal with valid/ready (stage is the source)
// master = environment side (drives inputs), slave = stage side.
interface imm_decode_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [2:0]      in_imm_src;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_imm_src, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_target, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_imm_src, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_target, out_illegal
  );
endinterface

// File: rtl/imm_skid_buf.sv
// imm_skid_buf: generic 2-entry valid/ready buffer.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid_i/in_ready_o/in_data_i    : upstream handshake
//   out_valid_o/out_ready_i/out_data_o : downstream handshake
// The "main" slot drives the outputs; "skid" catches the one word that can
// arrive in the cycle downstream stalls. in_ready_o is a flop, so there is no
// combinational path from out_ready_i to in_ready_o.
module imm_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  buf_state_t       state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             main_vld_q;
  logic             in_ready_q;
  logic             push;
  logic             pop;

  assign push = in_valid_i & in_ready_q;
  assign pop  = main_vld_q & out_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_q     <= in_data_i;
            main_vld_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            // Streaming case: reload main directly, never touch skid.
            main_q <= in_data_i;
          end else if (push) begin
            skid_q     <= in_data_i;
            in_ready_q <= 1'b0;
            state_q    <= FULL;
          end else if (pop) begin
            main_vld_q <= 1'b0;
            state_q    <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          main_vld_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= EMPTY;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = main_vld_q;
  assign out_data_o  = main_q;

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate generator with pc+imm target.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : imm_decode_stage_if.slave
//                in_valid/in_ready, in_instr, in_imm_src, in_pc  (upstream)
//                out_valid/out_ready, out_imm, out_target, out_illegal (down)
// Extension and the target adder are combinational ahead of a 2-entry skid
// buffer, giving 1-cycle latency and full throughput.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst_n,
  imm_decode_stage_if.slave bus
);

  localparam int BW = 2 * XLEN + 1;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  imm_ext_t        ext;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] target;
  logic [BW-1:0]   bundle_in;
  logic [BW-1:0]   bundle_out;
  logic            unused_ext_hi;

  assign ext    = imm_extend(bus.in_instr, bus.in_imm_src);
  assign imm    = ext.imm[XLEN-1:0];
  // Carry out is dropped on purpose: targets wrap modulo 2^XLEN.
  assign target = bus.in_pc + imm;

  // Upper extension bits are pure sign copies when XLEN is 32.
  assign unused_ext_hi = ^ext.imm;

  assign bundle_in = {imm, target, ext.illegal};

  imm_skid_buf #(.WIDTH(BW)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (bundle_in),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (bundle_out)
  );

  assign bus.out_imm     = bundle_out[BW-1 -: XLEN];
  assign bus.out_target  = bundle_out[XLEN:1];
  assign bus.out_illegal = bundle_out[0];

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench: an XLEN=32 and an XLEN=64 stage receive identical
// stimulus. Accepted inputs push an expected bundle; a monitor checks
// handshake occupancy and compares the head bundle while out_valid is high.
module tb_imm_decode_stage;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] instr = '0;
  logic [2:0]  src = '0;
  logic [63:0] pc = '0;

  imm_decode_stage_if #(.XLEN(32)) b32 ();
  imm_decode_stage_if #(.XLEN(64)) b64 ();

  assign b32.in_valid   = in_valid;
  assign b32.in_instr   = instr;
  assign b32.in_imm_src = src;
  assign b32.in_pc      = pc[31:0];
  assign b32.out_ready  = out_ready;
  assign b64.in_valid   = in_valid;
  assign b64.in_instr   = instr;
  assign b64.in_imm_src = src;
  assign b64.in_pc      = pc;
  assign b64.out_ready  = out_ready;

  imm_decode_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  imm_decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        ill;
  } exp_t;

  exp_t cur_exp;
  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sx(input longint val, input int bits);
    if (val >= (longint'(1) << (bits - 1))) return val - (longint'(1) << bits);
    return val;
  endfunction

  // Reference: field values assembled arithmetically, then sign-interpreted.
  function automatic exp_t model(input logic [31:0] ins, input logic [2:0] s,
                                 input logic [63:0] p);
    exp_t   e;
    longint v;
    e.ill = 1'b0;
    case (s)
      3'd0: v = sx(longint'(ins[31:20]), 12);
      3'd1: v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
      3'd2: v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                   + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      3'd3: v = sx(longint'(ins[31:12]), 20) * 4096;
      3'd4: v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                   + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      3'd5: v = longint'(ins[19:15]);
      default: begin v = 0; e.ill = 1'b1; end
    endcase
    e.imm = 64'(v);
    e.tgt = p + e.imm;
    return e;
  endfunction

  // Monitor / scoreboard. Inputs change only just after posedge, so values
  // seen here are what the next posedge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      chk("in_ready32", {63'b0, b32.in_ready}, {63'b0, q.size() < 2});
      chk("in_ready64", {63'b0, b64.in_ready}, {63'b0, q.size() < 2});
      chk("out_valid32", {63'b0, b32.out_valid}, {63'b0, q.size() > 0});
      chk("out_valid64", {63'b0, b64.out_valid}, {63'b0, q.size() > 0});
      if (q.size() > 0 && b32.out_valid) begin
        chk("imm32", {32'b0, b32.out_imm}, {32'b0, q[0].imm[31:0]});
        chk("tgt32", {32'b0, b32.out_target}, {32'b0, q[0].tgt[31:0]});
        chk("ill32", {63'b0, b32.out_illegal}, {63'b0, q[0].ill});
        chk("imm64", b64.out_imm, q[0].imm);
        chk("tgt64", b64.out_target, q[0].tgt);
        chk("ill64", {63'b0, b64.out_illegal}, {63'b0, q[0].ill});
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && b32.in_ready) q.push_back(cur_exp);
    end
  end

  // Present one instruction and hold it until accepted (bounded wait).
  task automatic send(input logic [31:0] i, input logic [2:0] s, input logic [63:0] p,
                      input logic [63:0] eimm, input logic [63:0] etgt, input logic eill);
    int n;
    instr = i; src = s; pc = p;
    cur_exp.imm = eimm; cur_exp.tgt = etgt; cur_exp.ill = eill;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!b32.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept t=%0t", $time);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [31:0] i;
    logic [2:0]  s;
    logic [63:0] p;
    exp_t        e;
    i = $urandom; s = 3'($urandom_range(0, 7)); p = {$urandom, $urandom};
    e = model(i, s, p);
    send(i, s, p, e.imm, e.tgt, e.ill);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_ovalid"}, {62'b0, b32.out_valid, b64.out_valid}, 64'd0);
    chk({tag, "_iready"}, {62'b0, b32.in_ready, b64.in_ready}, 64'd3);
    chk({tag, "_imm"}, {b32.out_imm, 32'b0} | b64.out_imm, 64'd0);
    chk({tag, "_tgt"}, {b32.out_target, 32'b0} | b64.out_target, 64'd0);
    chk({tag, "_ill"}, {62'b0, b32.out_illegal, b64.out_illegal}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Formats and targets, out_ready high.
    out_ready = 1'b1;
    send(32'hFFF00013, 3'd0, 64'h1000, 64'hFFFFFFFFFFFFFFFF, 64'h0FFF, 1'b0);
    send(32'h0064A423, 3'd1, 64'h1000, 64'h8, 64'h1008, 1'b0);
    send(32'hFE420AE3, 3'd2, 64'h1000, 64'hFFFFFFFFFFFFFFF4, 64'h0FF4, 1'b0);
    send(32'h12345037, 3'd3, 64'h1000, 64'h12345000, 64'h12346000, 1'b0);
    send(32'h7F8A60EF, 3'd4, 64'h1000, 64'h000A67F8, 64'h000A77F8, 1'b0);
    send(32'h0007D073, 3'd5, 64'h1000, 64'hF, 64'h100F, 1'b0);
    send(32'h00100013, 3'd0, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0, 1'b0);
    send(32'h80000037, 3'd3, 64'h0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0);
    send(32'hDEADBEEF, 3'd6, 64'h12345678ABCD, 64'h0, 64'h12345678ABCD, 1'b1);
    send(32'h00000000, 3'd7, 64'h00000000FFFFF000, 64'h0, 64'h00000000FFFFF000, 1'b1);
    repeat (3) @(posedge clk); #1;

    // Backpressure: 4 items with downstream stalled, then release.
    out_ready = 1'b0;
    fork
      repeat (4) send_rand();
      begin repeat (6) @(posedge clk); #1; out_ready = 1'b1; end
    join
    repeat (4) @(posedge clk); #1;

    // Mid-flight reset with buffer full.
    out_ready = 1'b0;
    send_rand();
    send_rand();
    rst_n = 1'b0;
    @(posedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Random traffic on both handshakes.
    for (int c = 0; c < 1500; c++) begin
      exp_t e;
      instr = $urandom;
      src = 3'($urandom_range(0, 7));
      pc = {$urandom, $urandom};
      e = model(instr, src, pc);
      cur_exp = e;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
